// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory access stage of a simple 16-bit pipeline.
//
// Non-memory instructions pass through with one cycle of latency. Loads and
// stores are issued on a registered request/acknowledge memory bus. The stage
// stalls the upstream pipeline until the access is acknowledged, and inserts
// writeback bubbles while the access is in progress.
//
// Optional feature: define MEM_STAGE_TIMEOUT_EN to add an 8-bit access
// timeout. An access that is not acknowledged is abandoned after 256 cycles,
// and memo_err pulses for one cycle. When the macro is undefined, the stage
// waits indefinitely for mem_ack and memo_err is tied to 0.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   memi_instr/pc/branch      pass-through from execute
//   memi_result               ALU result; the memory address for accesses
//   memi_wreg_addr            destination register (4'hF = none)
//   memi_write_to_mem_data    store data
//   memi_rwe                  00 none, 10 read, 01 write, 11 illegal
//   mem_addr/wdata/req/we     memory bus request (registered)
//   mem_rdata/mem_ack         memory bus response
//   memo_instr/pc/branch      registered pass-through
//   memo_wb_en/wreg_addr/data writeback request
//   mem_stall                 upstream must hold memi_* while high
//   memo_err                  one-cycle access-timeout pulse
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memi_instr,
    input  logic [15:0] memi_pc,
    input  logic [15:0] memi_result,
    input  logic [3:0]  memi_wreg_addr,
    input  logic [15:0] memi_write_to_mem_data,
    input  logic [1:0]  memi_rwe,
    input  logic        memi_branch,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] memo_instr,
    output logic [15:0] memo_pc,
    output logic        memo_branch,
    output logic        memo_wb_en,
    output logic [3:0]  memo_wreg_addr,
    output logic [15:0] memo_wb_data,
    output logic        mem_stall,
    output logic        memo_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        branch_q, branch_d;
    logic        wb_en_q, wb_en_d;
    logic [3:0]  wreg_q, wreg_d;
    logic [15:0] wb_data_q, wb_data_d;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_d     = req_q;
        we_d      = we_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        branch_d  = branch_q;
        wreg_d    = wreg_q;
        wb_data_d = wb_data_q;
        // Writeback is a per-cycle request; it is a bubble unless set below.
        wb_en_d   = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // The pass-through fields are captured in every IDLE cycle. For an
                // access, they are then held until the access completes.
                instr_d  = memi_instr;
                pc_d     = memi_pc;
                branch_d = memi_branch;
                wreg_d   = memi_wreg_addr;
                case (memi_rwe)
                    2'b10: begin
                        addr_d  = memi_result;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        state_d = READ;
`ifdef MEM_STAGE_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end
                    2'b01: begin
                        addr_d  = memi_result;
                        wdata_d = memi_write_to_mem_data;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        state_d = WRITE;
`ifdef MEM_STAGE_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end
                    default: begin
                        // Illegal access code 11 is treated as a no-op without writeback.
                        wb_data_d = memi_result;
                        wb_en_d   = (memi_rwe == 2'b00) && (memi_wreg_addr != 4'hF);
                    end
                endcase
            end
            READ, WRITE: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (state_q == READ) begin
                        wb_data_d = mem_rdata;
                        wb_en_d   = (wreg_q != 4'hF);
                    end
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (cnt_q == 8'hFF) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            instr_q   <= 16'h0000;
            pc_q      <= 16'h0000;
            branch_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            wreg_q    <= 4'h0;
            wb_data_q <= 16'h0000;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            req_q     <= req_d;
            we_q      <= we_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            branch_q  <= branch_d;
            wb_en_q   <= wb_en_d;
            wreg_q    <= wreg_d;
            wb_data_q <= wb_data_d;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign memo_instr     = instr_q;
    assign memo_pc        = pc_q;
    assign memo_branch    = branch_q;
    assign memo_wb_en     = wb_en_q;
    assign memo_wreg_addr = wreg_q;
    assign memo_wb_data   = wb_data_q;
    assign mem_stall      = (state_q != IDLE);
`ifdef MEM_STAGE_TIMEOUT_EN
    assign memo_err       = err_q;
`else
    assign memo_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Each transaction's expected outcome is derived from the stage's contract. A
// no-op returns its result one cycle later. An access holds its bus request,
// stalls, and bubbles until it is acknowledged, and then returns to IDLE.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memi_instr, memi_pc, memi_result, memi_write_to_mem_data;
    logic [3:0]  memi_wreg_addr;
    logic [1:0]  memi_rwe;
    logic        memi_branch;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] memo_instr, memo_pc, memo_wb_data;
    logic        memo_branch, memo_wb_en;
    logic [3:0]  memo_wreg_addr;
    logic        mem_stall, memo_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                    (clk),
        .rst                    (rst),
        .memi_instr             (memi_instr),
        .memi_pc                (memi_pc),
        .memi_result            (memi_result),
        .memi_wreg_addr         (memi_wreg_addr),
        .memi_write_to_mem_data (memi_write_to_mem_data),
        .memi_rwe               (memi_rwe),
        .memi_branch            (memi_branch),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_req                (mem_req),
        .mem_we                 (mem_we),
        .mem_rdata              (mem_rdata),
        .mem_ack                (mem_ack),
        .memo_instr             (memo_instr),
        .memo_pc                (memo_pc),
        .memo_branch            (memo_branch),
        .memo_wb_en             (memo_wb_en),
        .memo_wreg_addr         (memo_wreg_addr),
        .memo_wb_data           (memo_wb_data),
        .mem_stall              (mem_stall),
        .memo_err               (memo_err)
    );

    // Outputs are sampled 1 time unit after the active edge. Inputs are driven
    // at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A single transaction, checked against the behaviour it must produce.
    // For an access, delay is the number of request cycles before the ack cycle.
    task automatic do_txn(input logic [1:0] rwe, input logic [3:0] wreg,
                          input logic [15:0] res, input logic [15:0] wd,
                          input logic [15:0] rd, input int delay,
                          input logic garble, input string tag);
        logic [15:0] ins, pcv;
        logic        br, is_wr, exp_en;
        ins = 16'($urandom);
        pcv = 16'($urandom);
        br  = 1'($urandom);
        memi_instr = ins; memi_pc = pcv; memi_branch = br;
        memi_result = res; memi_wreg_addr = wreg; memi_rwe = rwe;
        memi_write_to_mem_data = wd;
        // While the stage is IDLE, an ack must be ignored.
        mem_ack = (rwe == 2'b00 || rwe == 2'b11) ? 1'($urandom) : 1'b0;
        mem_rdata = ~res;
        tick();
        if (rwe == 2'b00 || rwe == 2'b11) begin
            exp_en = (rwe == 2'b00) && (wreg != 4'hF);
            total++;
            if ({mem_stall, mem_req, memo_wb_en, memo_wreg_addr, memo_wb_data} !==
                {1'b0, 1'b0, exp_en, wreg, res}) begin
                bad++;
                $display("FAIL %s_noop: stall/req/en/wreg/data got %b/%b/%b/%h/%h want 0/0/%b/%h/%h",
                         tag, mem_stall, mem_req, memo_wb_en, memo_wreg_addr, memo_wb_data,
                         exp_en, wreg, res);
            end
            total++;
            if ({memo_instr, memo_pc, memo_branch} !== {ins, pcv, br}) begin
                bad++;
                $display("FAIL %s_pass: got %h/%h/%b want %h/%h/%b", tag,
                         memo_instr, memo_pc, memo_branch, ins, pcv, br);
            end
            $display("txn %s rwe=%b wreg=%h res=%h wb_en=%b", tag, rwe, wreg, res, memo_wb_en);
        end else begin
            is_wr = (rwe == 2'b01);
            for (int c = 0; c <= delay; c++) begin
                total++;
                if ({mem_req, mem_we, mem_addr, mem_stall, memo_wb_en, memo_err} !==
                    {1'b1, is_wr, res, 1'b1, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL %s_hold c=%0d: req/we/addr/stall/en/err got %b/%b/%h/%b/%b/%b want 1/%b/%h/1/0/0",
                             tag, c, mem_req, mem_we, mem_addr, mem_stall, memo_wb_en,
                             memo_err, is_wr, res);
                end
                if (is_wr) begin
                    total++;
                    if (mem_wdata !== wd) begin
                        bad++;
                        $display("FAIL %s_wdata: got %h want %h", tag, mem_wdata, wd);
                    end
                end
                if (c == delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                    if (garble) begin
                        // Inputs in the ack cycle must not disturb the result.
                        memi_instr = 16'($urandom); memi_pc = 16'($urandom);
                        memi_result = 16'($urandom); memi_wreg_addr = 4'($urandom);
                        memi_rwe = 2'($urandom); memi_branch = 1'($urandom);
                    end
                end
                tick();
            end
            mem_ack = 1'b0;
            exp_en = !is_wr && (wreg != 4'hF);
            total++;
            if ({mem_req, mem_stall, memo_wb_en, memo_wreg_addr, memo_instr, memo_pc} !==
                {1'b0, 1'b0, exp_en, wreg, ins, pcv}) begin
                bad++;
                $display("FAIL %s_done: req/stall/en/wreg/instr/pc got %b/%b/%b/%h/%h/%h want 0/0/%b/%h/%h/%h",
                         tag, mem_req, mem_stall, memo_wb_en, memo_wreg_addr, memo_instr,
                         memo_pc, exp_en, wreg, ins, pcv);
            end
            if (!is_wr) begin
                total++;
                if (memo_wb_data !== rd) begin
                    bad++;
                    $display("FAIL %s_rdata: got %h want %h", tag, memo_wb_data, rd);
                end
            end
            $display("txn %s rwe=%b addr=%h delay=%0d wb_en=%b wb_data=%h",
                     tag, rwe, res, delay, memo_wb_en, memo_wb_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        memi_instr = 16'hFFFF; memi_pc = 16'hFFFF; memi_result = 16'hFFFF;
        memi_wreg_addr = 4'h1; memi_rwe = 2'b10; memi_branch = 1'b1;
        memi_write_to_mem_data = 16'hFFFF; mem_rdata = 16'hFFFF; mem_ack = 1'b1;
        tick();
        tick();
        total++;
        if ({mem_addr, mem_wdata, mem_req, mem_we, memo_instr, memo_pc, memo_branch,
             memo_wb_en, memo_wreg_addr, memo_wb_data, mem_stall, memo_err} !== 90'd0) begin
            bad++;
            $display("FAIL reset: outputs not zero (req=%b stall=%b addr=%h instr=%h)",
                     mem_req, mem_stall, mem_addr, memo_instr);
        end
        $display("txn reset req=%b stall=%b", mem_req, mem_stall);
        rst = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_directed();
        do_txn(2'b00, 4'h3, 16'h1234, 16'h0000, 16'h0000, 0, 1'b0, "basic");
        do_txn(2'b10, 4'h5, 16'h0040, 16'h0000, 16'hBEEF, 2, 1'b0, "read3");
        do_txn(2'b01, 4'h6, 16'h0080, 16'h5A5A, 16'h0000, 0, 1'b0, "write1");
        do_txn(2'b11, 4'h2, 16'h2222, 16'h0000, 16'h0000, 0, 1'b0, "illegal");
        do_txn(2'b00, 4'hF, 16'h3333, 16'h0000, 16'h0000, 0, 1'b0, "noreg");
        do_txn(2'b10, 4'hF, 16'h0100, 16'h0000, 16'hCAFE, 0, 1'b0, "readF");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            do_txn(2'($urandom), w, 16'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 4)), 1'($urandom), "rand");
        end
    endtask

    task automatic test_reset_mid_access();
        memi_rwe = 2'b10; memi_result = 16'h0200; memi_wreg_addr = 4'h7;
        mem_ack = 1'b0;
        tick();
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        total++;
        if ({mem_req, mem_stall, memo_wb_en} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid: req/stall/en got %b/%b/%b want 0/0/0",
                     mem_req, mem_stall, memo_wb_en);
        end
        rst = 1'b0;
        memi_rwe = 2'b00; memi_wreg_addr = 4'hF; memi_result = 16'h1111;
        tick();
        total++;
        if ({mem_req, mem_stall, memo_wb_en, memo_wb_data} !== {3'b000, 16'h1111}) begin
            bad++;
            $display("FAIL late_ack: req/stall/en/data got %b/%b/%b/%h want 0/0/0/1111",
                     mem_req, mem_stall, memo_wb_en, memo_wb_data);
        end
        mem_ack = 1'b0;
        $display("txn reset_mid_access req=%b wb_en=%b", mem_req, memo_wb_en);
    endtask

    task automatic test_timeout();
        int err_at, stall_drop, err_seen;
        memi_rwe = 2'b10; memi_result = 16'h0300; memi_wreg_addr = 4'h4;
        mem_ack = 1'b0;
        tick();
`ifdef MEM_STAGE_TIMEOUT_EN
        err_at = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (memo_err === 1'b1) begin
                err_at = n;
                break;
            end
        end
        memi_rwe = 2'b00; memi_wreg_addr = 4'hF;
        total++;
        if (err_at != 256) begin
            bad++;
            $display("FAIL timeout_at: err after %0d cycles want 256", err_at);
        end
        total++;
        if ({mem_req, mem_stall, memo_wb_en} !== 3'b000) begin
            bad++;
            $display("FAIL timeout_idle: req/stall/en got %b/%b/%b want 0/0/0",
                     mem_req, mem_stall, memo_wb_en);
        end
        tick();
        total++;
        if (memo_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: err got %b want 0", memo_err);
        end
        stall_drop = 0; err_seen = 0;
        $display("txn timeout err_at=%0d", err_at);
`else
        stall_drop = 0; err_seen = 0; err_at = 0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (mem_stall !== 1'b1 || mem_req !== 1'b1) stall_drop++;
            if (memo_err !== 1'b0) err_seen++;
        end
        total++;
        if (stall_drop != 0 || err_seen != 0) begin
            bad++;
            $display("FAIL no_timeout: stall drops=%0d err cycles=%0d want 0/0",
                     stall_drop, err_seen);
        end
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        memi_rwe = 2'b00; memi_wreg_addr = 4'hF;
        tick();
        mem_ack = 1'b0;
        total++;
        if ({mem_req, mem_stall, memo_wb_en, memo_wb_data} !== {3'b001, 16'h7777}) begin
            bad++;
            $display("FAIL no_timeout_ack: req/stall/en/data got %b/%b/%b/%h want 0/0/1/7777",
                     mem_req, mem_stall, memo_wb_en, memo_wb_data);
        end
        $display("txn wait_forever stall_drops=%0d err=%0d", stall_drop, err_seen);
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_access();
        test_timeout();
        test_directed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
